image_write: RTL and testbench
==============================

Name: image_write

Overview:
- Sink end of the pixel stream produced by the image reader.
- Captures one frame delivered as two RGB888 pixels per clock, qualified by HSYNC and framed by VSYNC, into an internal frame buffer.
- Once the frame is complete, drains the buffer as a byte stream in BMP order (bottom row first, B,G,R per pixel) over a valid/ready handshake, for a file dumper or downstream DMA.

Parameters:
- WIDTH, 768, pixels per line; must be a multiple of 4 so BMP rows need no padding.
- HEIGHT, 512, lines per frame.
- BYTE_COUNT, WIDTH*HEIGHT*3, frame buffer size in bytes (derived; do not override).

Ports:
- HCLK  input  1  clock
- HRESET  input  1  asynchronous, active-high reset
- VSYNC  input  1  frame start; high for one or more cycles before the first line
- HSYNC  input  1  pixel-pair valid; DATA_* sampled on every HCLK edge where HSYNC=1
- DATA_R0/G0/B0  input  8 each  even-column pixel
- DATA_R1/G1/B1  input  8 each  odd-column pixel
- out_data  output  8  drained byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts byte when out_valid & out_ready
- capture_done  output  1  one-cycle pulse when the last pixel pair is stored
- drain_done  output  1  level; high in DONE
- frame_error  output  1  one-cycle pulse on VSYNC during CAPTURE
- pixel_drop  output  1  one-cycle pulse when HSYNC=1 outside CAPTURE

Behaviour:
- Reset (HRESET=1, asynchronous): state IDLE; all counters 0; out_data=0, out_valid=0, capture_done=0, drain_done=0, frame_error=0, pixel_drop=0. Buffer contents are not reset.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: VSYNC=1 -> CAPTURE, with col=0, row=0, pair_cnt=0.
- CAPTURE:
  - Each cycle with HSYNC=1, store pixel col at byte address base=WIDTH*3*(HEIGHT-1-row)+3*col as B0,G0,R0, then pixel col+1 at base+3 as B1,G1,R1.
  - col += 2. At col==WIDTH-2: col←0, row+1.
  - HSYNC=0 cycles are gaps: no write, no count change.
  - When the stored pair is number WIDTH*HEIGHT/2: pulse capture_done that same cycle; next state DRAIN.
  - VSYNC=1 while HSYNC=0 with pair_cnt>0: pulse frame_error, clear counters, stay in CAPTURE (restart frame).
  - VSYNC=1 with pair_cnt=0: no effect.
- DRAIN:
  - Byte address rd counts 0..BYTE_COUNT-1.
  - Output register: out_valid rises the cycle after DRAIN entry with out_data=buf[0].
  - On out_valid & out_ready, load buf[rd+1] the next cycle; out_valid stays 1, with no bubbles while out_ready=1.
  - While out_valid & !out_ready, out_data must hold stable.
  - Acceptance of byte BYTE_COUNT-1: out_valid←0, next state DONE.
- DONE: drain_done=1. VSYNC=1 -> CAPTURE (new frame), drain_done←0.
- pixel_drop pulses one cycle later for any HSYNC=1 cycle in IDLE, DRAIN or DONE; the data is discarded.
- Counter widths sized by $clog2: pair_cnt 18 b, rd 21 b at defaults.
- Reset mid-CAPTURE or mid-DRAIN: immediate return to IDLE, partial frame abandoned, out_valid drops asynchronously.

Optional Feature:
- Macro: BMP_HEADER_EN.
- Defined: DRAIN first emits a 54-byte BMP header through the same handshake, then the pixel bytes. Header fields, little-endian:
  - "BM" (0x42,0x4D)
  - file size 54+BYTE_COUNT
  - 4 reserved zero bytes
  - pixel offset 54
  - info size 40
  - WIDTH, HEIGHT
  - planes 1 (16 b), bpp 24 (16 b)
  - compression 0
  - image size BYTE_COUNT
  - 16 zero bytes
- Total bytes out = 54+BYTE_COUNT.
- Undefined: no header; exactly BYTE_COUNT bytes out.

Test Plan:
- WIDTH=4, HEIGHT=2, VSYNC pulse, then 4 HSYNC pairs: row0 pixels R=G=B=0x00..0x03, row1 0x10..0x13; out_ready=1 -> capture_done on the 4th pair; 24 bytes out in order 10,10,10,11,11,11,12,…,03,03,03; then drain_done=1.
- Same frame with HSYNC gaps of 3 cycles between pairs -> identical output bytes.
- Same frame, out_ready toggled 1,0,0,1 repeatedly -> out_data unchanged while stalled; 24 bytes, no loss or duplication.
- VSYNC asserted after 2 pairs, then a full fresh frame -> frame_error pulse once; output equals the fresh frame only.
- HSYNC=1 during DRAIN -> pixel_drop pulse; drained bytes unchanged. HRESET mid-DRAIN -> out_valid=0 immediately, state IDLE.
- With BMP_HEADER_EN at defaults -> first bytes 42 4D 36 00 12 00 00 00 00 00 36 00 00 00 28 00 00 00 00 03 00 00 00 02 00 00; 1179702 bytes in total.

Source files
------------

// File: rtl/image_write.sv
// Frame sink: stores one dual-pixel RGB888 frame, then drains it as a bottom-up B,G,R byte stream.
// Build option BMP_HEADER_EN prefixes the drained stream with a 54-byte BMP file header.
module image_write #(
   parameter int unsigned WIDTH      = 768,
   parameter int unsigned HEIGHT     = 512,
   parameter int unsigned BYTE_COUNT = WIDTH * HEIGHT * 3
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       VSYNC,
   input  logic       HSYNC,
   input  logic [7:0] DATA_R0,
   input  logic [7:0] DATA_G0,
   input  logic [7:0] DATA_B0,
   input  logic [7:0] DATA_R1,
   input  logic [7:0] DATA_G1,
   input  logic [7:0] DATA_B1,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       capture_done,
   output logic       drain_done,
   output logic       frame_error,
   output logic       pixel_drop
);

   localparam int unsigned Pairs = WIDTH * HEIGHT / 2;
`ifdef BMP_HEADER_EN
   localparam int unsigned HdrLen = 54;
`else
   localparam int unsigned HdrLen = 0;
`endif
   localparam int unsigned Total = BYTE_COUNT + HdrLen;
   localparam int unsigned PcW   = $clog2(Pairs + 1);
   localparam int unsigned ColW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned WordW = (Pairs > 1) ? $clog2(Pairs) : 1;
   localparam int unsigned RdW   = $clog2(Total + 1);

   typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [ColW-1:0]    col_q;
   logic [PcW-1:0]     pair_cnt_q;
   logic [WordW-1:0]   wr_word_q;
   logic [RdW-1:0]     rd_q;
   logic [WordW-1:0]   rd_word_q;
   logic [2:0]         rd_lane_q;
   logic [7:0]         out_data_q;
   logic               out_valid_q;
   logic               pixel_drop_q;

   // One word holds a pixel pair: six consecutive BMP bytes, B0 in the low lane.
   logic [47:0]        mem [Pairs];

   logic store, last_pair, last_col, all_loaded, accept, load;

   assign store      = (state_q == StCapture) && HSYNC;
   assign last_pair  = (pair_cnt_q == PcW'(Pairs - 1));
   assign last_col   = (col_q == ColW'(WIDTH - 2));
   assign all_loaded = (rd_q == RdW'(Total));
   assign accept     = out_valid_q && out_ready;
   assign load       = (state_q == StDrain) && (!out_valid_q || out_ready) && !all_loaded;

`ifdef BMP_HEADER_EN
   logic in_hdr;
   assign in_hdr = (rd_q < RdW'(HdrLen));

   // Past the "BM" magic every field is a 32-bit little-endian slot starting at byte 2;
   // planes and bpp share slot 6 as two 16-bit halves.
   function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
      logic [5:0]  off;
      logic [31:0] field;
      off = idx - 6'd2;
      unique case (off[5:2])
         4'd0:    field = 32'(BYTE_COUNT + 54);
         4'd2:    field = 32'd54;
         4'd3:    field = 32'd40;
         4'd4:    field = 32'(WIDTH);
         4'd5:    field = 32'(HEIGHT);
         4'd6:    field = {16'd24, 16'd1};
         4'd8:    field = 32'(BYTE_COUNT);
         default: field = 32'd0;
      endcase
      if (idx == 6'd0)      hdr_byte = 8'h42;
      else if (idx == 6'd1) hdr_byte = 8'h4D;
      else                  hdr_byte = field[{off[1:0], 3'b000} +: 8];
   endfunction
`endif

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (VSYNC) state_d = StCapture;
         StCapture: if (store && last_pair) state_d = StDrain;
         StDrain:   if (accept && all_loaded) state_d = StDone;
         StDone:    if (VSYNC) state_d = StCapture;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      capture_done = 1'b0;
      frame_error  = 1'b0;
      drain_done   = 1'b0;
      unique case (state_q)
         StCapture: begin
            capture_done = HSYNC && last_pair;
            frame_error  = VSYNC && !HSYNC && (pair_cnt_q != '0);
         end
         StDone:  drain_done = 1'b1;
         default: ;
      endcase
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign pixel_drop = pixel_drop_q;

   always_ff @(posedge HCLK) begin
      if (store) mem[wr_word_q] <= {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         col_q        <= '0;
         pair_cnt_q   <= '0;
         wr_word_q    <= '0;
         rd_q         <= '0;
         rd_word_q    <= '0;
         rd_lane_q    <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         pixel_drop_q <= 1'b0;
      end else begin
         pixel_drop_q <= HSYNC && (state_q != StCapture);

         // Rows land bottom-up: start at the last row's word and step back a line per row.
         if ((state_q != StCapture) || frame_error) begin
            col_q      <= '0;
            pair_cnt_q <= '0;
            wr_word_q  <= WordW'((HEIGHT - 1) * (WIDTH / 2));
         end else if (store) begin
            pair_cnt_q <= pair_cnt_q + 1'b1;
            if (last_col) begin
               col_q     <= '0;
               wr_word_q <= wr_word_q - WordW'(WIDTH - 1);
            end else begin
               col_q     <= col_q + ColW'(2);
               wr_word_q <= wr_word_q + 1'b1;
            end
         end

         if (state_q != StDrain) begin
            rd_q        <= '0;
            rd_word_q   <= '0;
            rd_lane_q   <= '0;
            out_valid_q <= 1'b0;
         end else if (load) begin
            rd_q        <= rd_q + 1'b1;
            out_valid_q <= 1'b1;
`ifdef BMP_HEADER_EN
            if (in_hdr) out_data_q <= hdr_byte(rd_q[5:0]);
            else
`endif
            begin
               out_data_q <= mem[rd_word_q][{rd_lane_q, 3'b000} +: 8];
               if (rd_lane_q == 3'd5) begin
                  rd_lane_q <= '0;
                  rd_word_q <= rd_word_q + 1'b1;
               end else begin
                  rd_lane_q <= rd_lane_q + 1'b1;
               end
            end
         end else if (accept) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_image_write.sv
// Scoreboard bench for image_write on a 4x2 frame: capture, gaps, stalls, restart, drops, reset.
module tb_image_write;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;
   localparam int unsigned BC = W * H * 3;
   localparam int unsigned P  = W * H / 2;

   logic       HCLK = 1'b0;
   logic       HRESET, VSYNC, HSYNC, out_ready;
   logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
   logic [7:0] out_data;
   logic       out_valid, capture_done, drain_done, frame_error, pixel_drop;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];

   always #5 HCLK = ~HCLK;

   image_write #(.WIDTH(W), .HEIGHT(H)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
      .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
      .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .capture_done(capture_done), .drain_done(drain_done),
      .frame_error(frame_error), .pixel_drop(pixel_drop)
   );

   // Pixel (r,c) of a frame: B = base+16r+c, G = B+off, R = B+2*off.
   task automatic set_pair(input int r, input int c, input int base, input int off);
      int v;
      v = base + r * 16 + c;
      DATA_B0 = 8'(v);     DATA_G0 = 8'(v + off);     DATA_R0 = 8'(v + 2 * off);
      DATA_B1 = 8'(v + 1); DATA_G1 = 8'(v + 1 + off); DATA_R1 = 8'(v + 1 + 2 * off);
   endtask

   task automatic push_frame(input int base, input int off);
`ifdef BMP_HEADER_EN
      logic [7:0]  h[54];
      int unsigned fo[8] = '{2, 10, 14, 18, 22, 26, 28, 34};
      int unsigned fv[8] = '{54 + BC, 54, 40, W, H, 1, 24, BC};
      for (int i = 0; i < 54; i++) h[i] = 8'h00;
      h[0] = 8'h42;
      h[1] = 8'h4D;
      for (int j = 0; j < 8; j++)
         for (int b = 0; b < 4; b++) h[fo[j] + b] = 8'(fv[j] >> (8 * b));
      for (int i = 0; i < 54; i++) exp_q.push_back(h[i]);
`endif
      for (int r = H - 1; r >= 0; r--)
         for (int c = 0; c < W; c++) begin
            exp_q.push_back(8'(base + r * 16 + c));
            exp_q.push_back(8'(base + r * 16 + c + off));
            exp_q.push_back(8'(base + r * 16 + c + 2 * off));
         end
   endtask

   task automatic drive_frame(input int gap, input int base, input int off);
      push_frame(base, off);
      @(negedge HCLK);
      VSYNC = 1'b1;
      HSYNC = 1'b0;
      #1;
      checks++;
      if (frame_error !== 1'b0) begin
         failures++;
         $display("FAIL vsync_no_error got=%b exp=0", frame_error);
      end
      for (int p = 0; p < P; p++) begin
         @(negedge HCLK);
         VSYNC = 1'b0;
         HSYNC = 1'b1;
         set_pair(p / (W / 2), 2 * (p % (W / 2)), base, off);
         #1;
         checks++;
         if (capture_done !== 1'(p == P - 1)) begin
            failures++;
            $display("FAIL capture_done pair=%0d got=%b exp=%b", p, capture_done, p == P - 1);
         end
         if (p < P - 1)
            repeat (gap) begin
               @(negedge HCLK);
               HSYNC = 1'b0;
            end
      end
      @(negedge HCLK);
      HSYNC = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_on_drain_entry got=%b exp=0", out_valid);
      end
   endtask

   // mode 0: out_ready held high; mode 1: out_ready cycles 1,0,0,1.
   task automatic collect(input int mode);
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int cyc = 0;
      while (exp_q.size() > 0 && cyc < 500) begin
         @(negedge HCLK);
         out_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
         cyc++;
         #1;
         checks++;
         if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL valid_held cyc=%0d got=%b exp=1", cyc, out_valid);
         end else begin
            checks++;
            if (out_data !== exp_q[0]) begin
               failures++;
               $display("FAIL drain_byte left=%0d got=%h exp=%h", exp_q.size(), out_data, exp_q[0]);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout got=%0d_left exp=0_left", exp_q.size());
         exp_q.delete();
      end
      @(negedge HCLK);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || drain_done !== 1'b1) begin
         failures++;
         $display("FAIL drain_end got=valid%b_done%b exp=valid0_done1", out_valid, drain_done);
      end
   endtask

   task automatic test_reset;
      HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; out_ready = 1'b1;
      set_pair(0, 0, 0, 0);
      repeat (2) @(negedge HCLK);
      #1;
      checks++;
      if ({out_data, out_valid, capture_done, drain_done, frame_error, pixel_drop} !== 13'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h/%b%b%b%b%b exp=0", out_data, out_valid,
                  capture_done, drain_done, frame_error, pixel_drop);
      end
      @(negedge HCLK);
      HRESET = 1'b0;
   endtask

   task automatic test_basic;
      drive_frame(0, 8'h00, 0);
      collect(0);
   endtask

   task automatic test_gaps;
      drive_frame(3, 8'h00, 0);
      collect(0);
   endtask

   task automatic test_stall;
      drive_frame(0, 8'h40, 8'h40);
      collect(1);
   endtask

   task automatic test_frame_error;
      @(negedge HCLK);
      VSYNC = 1'b1;
      for (int p = 0; p < 2; p++) begin
         @(negedge HCLK);
         VSYNC = 1'b0;
         HSYNC = 1'b1;
         set_pair(0, 2 * p, 8'hA0, 8'h01);
      end
      @(negedge HCLK);
      HSYNC = 1'b0;
      VSYNC = 1'b1;
      #1;
      checks++;
      if (frame_error !== 1'b1) begin
         failures++;
         $display("FAIL frame_error_pulse got=%b exp=1", frame_error);
      end
      @(negedge HCLK);
      VSYNC = 1'b0;
      #1;
      checks++;
      if (frame_error !== 1'b0) begin
         failures++;
         $display("FAIL frame_error_single got=%b exp=0", frame_error);
      end
      drive_frame(0, 8'h20, 8'h10);
      collect(0);
   endtask

   task automatic test_pixel_drop;
      drive_frame(0, 8'h60, 8'h08);
      HSYNC = 1'b1;
      out_ready = 1'b0;
      set_pair(1, 0, 8'hF0, 8'h01);
      @(negedge HCLK);
      HSYNC = 1'b0;
      #1;
      checks++;
      if (pixel_drop !== 1'b1) begin
         failures++;
         $display("FAIL pixel_drop_drain got=%b exp=1", pixel_drop);
      end
      collect(0);
   endtask

   task automatic test_reset_mid_drain;
      drive_frame(0, 8'h30, 8'h01);
      for (int i = 0; i < 5; i++) begin
         @(negedge HCLK);
         out_ready = 1'b1;
         #1;
         if (out_valid) begin
            checks++;
            if (out_data !== exp_q[0]) begin
               failures++;
               $display("FAIL pre_reset_byte got=%h exp=%h", out_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
      @(negedge HCLK);
      out_ready = 1'b0;
      #2;
      HRESET = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || drain_done !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got=valid%b_done%b exp=valid0_done0", out_valid, drain_done);
      end
      @(negedge HCLK);
      HRESET = 1'b0;
      out_ready = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge HCLK);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got=%b exp=0", out_valid);
      end
      drive_frame(0, 8'h50, 8'h20);
      collect(0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_stall();
      test_frame_error();
      test_pixel_drop();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
